// File: rtl/fetch_pkg.sv
// Shared definitions for the PC fetch unit: state encoding, reset PC and PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    // Instruction addresses are word aligned; the low two bits are forced to zero.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: a redirect wins, otherwise advance by PC_INCR, otherwise hold.
module pc_next_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        advance,
    output logic [31:0] pc_next
);

    // Priority mux: redirect > increment (wraps modulo 2^32) > hold.
    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = align_pc(redirect_target);
        end else if (advance) begin
            pc_next = pc + PC_INCR;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect/kill handling.
//
// Handshakes:
//   memory side  : imem_req is held high with a stable imem_addr until imem_ack;
//                  imem_ack with imem_req low is ignored.
//   consumer side: instr/instr_pc are transferred when instr_valid=1 and stall=0;
//                  instr_valid stays high and data stays stable while stalled.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         start,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_target,
    input  logic         stall,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc,
    output logic         instr_valid,
    output logic [31:0]  pc,
    output logic [15:0]  fetch_count,
    output fetch_state_e dbg_state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_next;
    logic [31:0]  fetch_addr_q, fetch_addr_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic         kill_q, kill_d;
    logic [15:0]  count_q, count_d;
    logic         advance;

    // The PC only steps on a live (not killed) ack; redirect priority is inside the selector.
    assign advance = (state_q == ST_FETCH) && imem_ack && !kill_q;

    pc_next_sel u_pc_next_sel (
        .pc              (pc_q),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .advance         (advance),
        .pc_next         (pc_next)
    );

    // State register and datapath registers; start clears everything asynchronously.
    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            fetch_addr_q  <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            kill_q        <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_next;
            fetch_addr_q  <= fetch_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            kill_q        <= kill_d;
            count_q       <= count_d;
        end
    end

    // Next-state logic. Whenever a new fetch is (re)started the fetch address is
    // taken from pc_next, which is the redirect target when one is present and
    // the current pc otherwise.
    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        kill_d        = kill_q;
        count_d       = count_q;
        case (state_q)
            ST_IDLE: begin
                state_d       = ST_FETCH;
                fetch_addr_d  = pc_next;
                instr_valid_d = 1'b0;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    if (imem_ack) begin
                        // Data in flight is stale; restart at the target right away.
                        fetch_addr_d = pc_next;
                        kill_d       = 1'b0;
                    end else begin
                        // Request must complete at its old address; drop its data later.
                        kill_d = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (kill_q) begin
                        kill_d       = 1'b0;
                        fetch_addr_d = pc_next;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = fetch_addr_q;
                        instr_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                    fetch_addr_d  = pc_next;
                end else if (!stall) begin
                    count_d       = count_q + 16'd1;
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                    fetch_addr_d  = pc_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = fetch_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign fetch_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with RESET_PC = 32'h00022200.
module tb_pc_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0002_2200;

    logic               clk;
    logic               start;
    logic               redirect_valid;
    logic [31:0]        redirect_target;
    logic               stall;
    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic [31:0]        instr;
    logic [31:0]        instr_pc;
    logic               instr_valid;
    logic [31:0]        pc;
    logic [15:0]        fetch_count;
    fetch_state_e       dbg_state;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .start           (start),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .pc              (pc),
        .fetch_count     (fetch_count),
        .dbg_state       (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Complete the current request with a one-cycle ack; ends in HOLD.
    task automatic ack_now(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    initial begin
        start           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        stall           = 1'b0;
        imem_ack        = 1'b0;
        imem_rdata      = '0;
        tick();
        tick();

        // Reset state
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_pc", pc, RST_PC);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);

        // Sequential fetch: 22200, 22204, 22208
        start = 1'b0;
        tick();
        chk("seq0_req", 32'(imem_req), 32'd1);
        chk("seq0_addr", imem_addr, 32'h0002_2200);
        ack_now(32'hA000_0000);
        chk("seq0_valid", 32'(instr_valid), 32'd1);
        chk("seq0_instr", instr, 32'hA000_0000);
        chk("seq0_instr_pc", instr_pc, 32'h0002_2200);
        chk("seq0_hold_req", 32'(imem_req), 32'd0);
        chk("seq0_pc", pc, 32'h0002_2204);
        tick();
        chk("seq1_count", 32'(fetch_count), 32'd1);
        chk("seq1_addr", imem_addr, 32'h0002_2204);
        chk("seq1_valid", 32'(instr_valid), 32'd0);
        ack_now(32'hA000_0001);
        chk("seq1_instr_pc", instr_pc, 32'h0002_2204);
        tick();
        chk("seq2_addr", imem_addr, 32'h0002_2208);
        ack_now(32'hA000_0002);
        chk("seq2_instr", instr, 32'hA000_0002);
        tick();
        chk("seq_count3", 32'(fetch_count), 32'd3);
        chk("seq3_addr", imem_addr, 32'h0002_220C);

        // Stall in HOLD for 5 cycles
        ack_now(32'hB000_0000);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr, 32'hB000_0000);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_count", 32'(fetch_count), 32'd3);
        end
        stall = 1'b0;
        tick();
        chk("unstall_count", 32'(fetch_count), 32'd4);
        chk("unstall_req", 32'(imem_req), 32'd1);
        chk("unstall_addr", imem_addr, 32'h0002_2210);

        // Redirect in FETCH, ack delayed 3 cycles
        redirect_valid  = 1'b1;
        redirect_target = 32'h0001_1103;
        tick();
        redirect_valid  = 1'b0;
        redirect_target = '0;
        chk("kill_pc", pc, 32'h0001_1100);
        for (int i = 0; i < 2; i++) begin
            chk("kill_addr_held", imem_addr, 32'h0002_2210);
            chk("kill_req_held", 32'(imem_req), 32'd1);
            tick();
        end
        chk("kill_addr_held", imem_addr, 32'h0002_2210);
        ack_now(32'hDEAD_BEEF);
        chk("kill_drop_valid", 32'(instr_valid), 32'd0);
        chk("kill_req", 32'(imem_req), 32'd1);
        chk("kill_new_addr", imem_addr, 32'h0001_1100);
        ack_now(32'hC000_0000);
        chk("kill_next_instr", instr, 32'hC000_0000);
        chk("kill_next_instr_pc", instr_pc, 32'h0001_1100);
        tick();
        chk("kill_count", 32'(fetch_count), 32'd5);
        chk("kill_next_addr", imem_addr, 32'h0001_1104);

        // Redirect in the same cycle as ack
        redirect_valid  = 1'b1;
        redirect_target = 32'h0003_3330;
        ack_now(32'hBAD0_0000);
        redirect_valid  = 1'b0;
        chk("redack_valid", 32'(instr_valid), 32'd0);
        chk("redack_req", 32'(imem_req), 32'd1);
        chk("redack_addr", imem_addr, 32'h0003_3330);
        chk("redack_pc", pc, 32'h0003_3330);
        ack_now(32'hD000_0000);
        chk("redack_instr_pc", instr_pc, 32'h0003_3330);

        // Redirect in HOLD coinciding with acceptance: no count, fetch at target
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid  = 1'b0;
        chk("redhold_count", 32'(fetch_count), 32'd5);
        chk("redhold_valid", 32'(instr_valid), 32'd0);
        chk("redhold_addr", imem_addr, 32'hFFFF_FFFC);

        // PC wrap
        ack_now(32'hE000_0000);
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'h0000_0000);
        tick();
        chk("wrap_count", 32'(fetch_count), 32'd6);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset mid-fetch with late ack
        start = 1'b1;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hF000_0000;
        tick();
        tick();
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_instr", instr, 32'd0);
        chk("midrst_count", 32'(fetch_count), 32'd0);
        chk("midrst_pc", pc, RST_PC);
        chk("midrst_addr", imem_addr, RST_PC);
        imem_ack   = 1'b0;
        imem_rdata = '0;
        start      = 1'b0;
        tick();
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, RST_PC);

        // Redirect wins over stall in HOLD
        ack_now(32'h1111_1111);
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0004_4446;
        tick();
        redirect_valid  = 1'b0;
        stall           = 1'b0;
        chk("redstall_valid", 32'(instr_valid), 32'd0);
        chk("redstall_req", 32'(imem_req), 32'd1);
        chk("redstall_addr", imem_addr, 32'h0004_4444);
        chk("redstall_count", 32'(fetch_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
